// File: rtl/axil_regfile_slave.sv
// axil_regfile_slave: AXI4-Lite slave register file, NUM_REGS x DATA_WIDTH registers.
// AW and W are accepted independently in any order; byte strobes honoured; range-checked
// decode. Every register is exported flat on regs_o, with a per-register commit strobe.
// Optional build macro: AXIL_SLV_SLVERR_EN (out-of-range accesses answer SLVERR, else OKAY).
module axil_regfile_slave #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned IDX_SPAN = 2 ** IDX_W;

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLV_SLVERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

    // write channel state
    wr_state_e                wr_state_q, wr_state_d;
    logic                     aw_held_q, aw_held_d;
    logic                     w_held_q, w_held_d;
    logic [IDX_W-1:0]         aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [STRB_W-1:0]        wstrb_q, wstrb_d;
    logic                     awready_q, awready_d;
    logic                     wready_q, wready_d;
    logic                     bvalid_q, bvalid_d;
    logic [1:0]               bresp_q, bresp_d;
    logic [NUM_REGS-1:0]      wr_pulse_q, wr_pulse_d;

    // read channel state
    rd_state_e                rd_state_q, rd_state_d;
    logic                     arready_q, arready_d;
    logic                     rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [1:0]               rresp_q, rresp_d;

    // register storage
    logic [DATA_WIDTH-1:0]    regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]    regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0]    regs_pad [IDX_SPAN];

    logic                     commit;
    logic                     wr_in_range;
    logic                     rd_in_range;
    logic [IDX_W-1:0]         ar_idx;
    logic [DATA_WIDTH-1:0]    wmask;

    // sub-word address bits carry no information for word-wide registers
    logic                     unused_addr_lsbs;
    assign unused_addr_lsbs = ^{awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

    assign commit      = (wr_state_q == WR_IDLE) && aw_held_q && w_held_q;
    assign wr_in_range = (32'(aw_idx_q) < NUM_REGS);
    assign ar_idx      = araddr[ADDR_WIDTH-1:ADDR_LSB];
    assign rd_in_range = (32'(ar_idx) < NUM_REGS);

    // byte-lane write mask from the held strobes
    for (genvar gk = 0; gk < STRB_W; gk++) begin : g_mask
        assign wmask[gk*8 +: 8] = {8{wstrb_q[gk]}};
    end

    // per-register commit, strobe and flat export
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        assign wr_pulse_d[gi] = commit && (aw_idx_q == IDX_W'(gi));
        assign regs_d[gi]     = wr_pulse_d[gi] ? ((regs_q[gi] & ~wmask) | (wdata_q & wmask))
                                               : regs_q[gi];
        assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
    end

    // read view padded to the full index space; unimplemented slots read as zero
    for (genvar gp = 0; gp < IDX_SPAN; gp++) begin : g_pad
        if (gp < NUM_REGS) begin : g_real
            assign regs_pad[gp] = regs_q[gp];
        end else begin : g_zero
            assign regs_pad[gp] = '0;
        end
    end

    // write FSM next state: hold AW/W independently, commit once both are held
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (commit) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                    bvalid_d   = 1'b1;
                    bresp_d    = wr_in_range ? RESP_OKAY : RESP_OOR;
                    wr_state_d = WR_RESP;
                end else begin
                    if (awvalid && awready_q) begin
                        aw_held_d = 1'b1;
                        aw_idx_d  = awaddr[ADDR_WIDTH-1:ADDR_LSB];
                    end
                    if (wvalid && wready_q) begin
                        w_held_d = 1'b1;
                        wdata_d  = wdata;
                        wstrb_d  = wstrb;
                    end
                    awready_d = !aw_held_d;
                    wready_d  = !w_held_d;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    bvalid_d   = 1'b0;
                    bresp_d    = RESP_OKAY;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // read FSM next state: capture data on the AR handshake, hold until rready
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    rdata_d    = regs_pad[ar_idx];
                    rresp_d    = rd_in_range ? RESP_OKAY : RESP_OOR;
                    rvalid_d   = 1'b1;
                    arready_d  = 1'b0;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rready) begin
                    rvalid_d   = 1'b0;
                    rdata_d    = '0;
                    rresp_d    = RESP_OKAY;
                    arready_d  = 1'b1;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // all state and registered outputs, synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state_q <= WR_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            regs_q     <= '{default: '0};
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            regs_q     <= regs_d;
        end
    end

    assign awready    = awready_q;
    assign wready     = wready_q;
    assign bvalid     = bvalid_q;
    assign bresp      = bresp_q;
    assign arready    = arready_q;
    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;
    assign rresp      = rresp_q;
    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_axil_regfile_slave.sv
// tb_axil_regfile_slave: directed and randomized checks of axil_regfile_slave
// (DATA_WIDTH=32, ADDR_WIDTH=6, NUM_REGS=8) against a word-array reference model.
`timescale 1ns/1ps
module tb_axil_regfile_slave;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 6;
    localparam int unsigned NR = 8;
`ifdef AXIL_SLV_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [AW-1:0]     awaddr;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [AW-1:0]     araddr;
    logic              arvalid;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [NR*DW-1:0]  regs_o;
    logic [NR-1:0]     wr_pulse_o;

    axil_regfile_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int passes = 0;
    logic [31:0] model [NR];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        f = '0;
        for (int i = 0; i < int'(NR); i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    function automatic bit in_range(input logic [5:0] a);
        return a[5:2] < 4'(NR);
    endfunction

    function automatic logic [1:0] exp_resp(input logic [5:0] a);
        return in_range(a) ? 2'b00 : OOR_RESP;
    endfunction

    function automatic logic [31:0] model_read(input logic [5:0] a);
        logic [3:0] idx;
        idx = a[5:2];
        return in_range(a) ? model[idx[2:0]] : 32'h0;
    endfunction

    task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [3:0] idx;
        idx = a[5:2];
        if (in_range(a))
            for (int k = 0; k < 4; k++)
                if (s[k]) model[idx[2:0]][k*8 +: 8] = d[k*8 +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(NR); i++) model[i] = 32'h0;
    endtask

    // full write: AW offered from cycle aw_at, W from cycle w_at, B held off b_hold cycles
    task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_at, input int w_at, input int b_hold);
        bit aw_done, w_done, aw_hs, w_hs;
        int t;
        logic [1:0] er;
        logic [7:0] ep;
        logic [3:0] idx;
        aw_done = 1'b0; w_done = 1'b0; t = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && t < 100) begin
            awvalid = !aw_done && (t >= aw_at);
            wvalid  = !w_done && (t >= w_at);
            if (w_done)  check("wready_while_w_held", 256'(wready), 256'(1'b0));
            if (aw_done) check("awready_while_aw_held", 256'(awready), 256'(1'b0));
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge aclk); #1;
            if (aw_hs) aw_done = 1'b1;
            if (w_hs)  w_done = 1'b1;
            t++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("aw_w_handshake_timeout", 256'(aw_done && w_done), 256'(1'b1));
        idx = addr[5:2];
        er  = exp_resp(addr);
        ep  = in_range(addr) ? 8'(1 << idx) : 8'h00;
        check("bvalid_not_yet", 256'(bvalid), 256'(1'b0));
        @(posedge aclk); #1;
        model_write(addr, data, strb);
        check("bvalid", 256'(bvalid), 256'(1'b1));
        check("bresp", 256'(bresp), 256'(er));
        check("wr_pulse", 256'(wr_pulse_o), 256'(ep));
        check("regs_after_commit", 256'(regs_o), model_flat());
        for (int i = 0; i < b_hold; i++) begin
            awvalid = 1'b1;
            @(posedge aclk); #1;
            check("bvalid_hold", 256'(bvalid), 256'(1'b1));
            check("bresp_hold", 256'(bresp), 256'(er));
            check("awready_in_resp", 256'(awready), 256'(1'b0));
            check("wready_in_resp", 256'(wready), 256'(1'b0));
            check("wr_pulse_one_cycle", 256'(wr_pulse_o), 256'(0));
        end
        awvalid = 1'b0;
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        check("bvalid_after_b", 256'(bvalid), 256'(1'b0));
        check("wr_pulse_after_b", 256'(wr_pulse_o), 256'(0));
        check("awready_after_b", 256'(awready), 256'(1'b1));
        check("wready_after_b", 256'(wready), 256'(1'b1));
    endtask

    // full read with rready held off r_hold cycles
    task automatic do_read(input logic [5:0] addr, input int r_hold);
        bit done, hs;
        int t;
        logic [31:0] ed;
        logic [1:0] er;
        done = 1'b0; t = 0; ed = '0;
        araddr = addr;
        er = exp_resp(addr);
        while (!done && t < 100) begin
            arvalid = 1'b1;
            hs = arready;
            ed = model_read(addr);
            @(posedge aclk); #1;
            done = hs;
            t++;
        end
        arvalid = 1'b0;
        check("ar_handshake_timeout", 256'(done), 256'(1'b1));
        check("rvalid", 256'(rvalid), 256'(1'b1));
        check("rdata", 256'(rdata), 256'(ed));
        check("rresp", 256'(rresp), 256'(er));
        for (int i = 0; i < r_hold; i++) begin
            @(posedge aclk); #1;
            check("rvalid_hold", 256'(rvalid), 256'(1'b1));
            check("rdata_hold", 256'(rdata), 256'(ed));
            check("rresp_hold", 256'(rresp), 256'(er));
            check("arready_in_data", 256'(arready), 256'(1'b0));
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        check("rvalid_after_r", 256'(rvalid), 256'(1'b0));
        check("arready_after_r", 256'(arready), 256'(1'b1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, 256'(awready), 256'(0));
        check({tag, "_wready"},  256'(wready),  256'(0));
        check({tag, "_arready"}, 256'(arready), 256'(0));
        check({tag, "_bvalid"},  256'(bvalid),  256'(0));
        check({tag, "_bresp"},   256'(bresp),   256'(0));
        check({tag, "_rvalid"},  256'(rvalid),  256'(0));
        check({tag, "_rdata"},   256'(rdata),   256'(0));
        check({tag, "_rresp"},   256'(rresp),   256'(0));
        check({tag, "_regs"},    256'(regs_o),  256'(0));
        check({tag, "_pulse"},   256'(wr_pulse_o), 256'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        logic [5:0]  ra;
        aresetn = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        model_clear();
        repeat (3) @(posedge aclk);
        #1;
        check_all_zero("reset");
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("idle_awready", 256'(awready), 256'(1'b1));
        check("idle_wready",  256'(wready),  256'(1'b1));
        check("idle_arready", 256'(arready), 256'(1'b1));

        // AW and W together, then read back
        do_write(6'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(6'h08, 0);

        // W three cycles ahead of AW, low half-word only
        do_write(6'h08, 32'h12345678, 4'h3, 3, 0, 0);
        check("partial_strobe_reg2", 256'(regs_o[95:64]), 256'(32'hDEAD5678));

        // B held off five cycles, AW retried meanwhile
        do_write(6'h0C, 32'hCAFEF00D, 4'hF, 0, 1, 5);
        do_read(6'h0C, 1);

        // out-of-range write is dropped, read returns zero
        do_write(6'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        do_read(6'h20, 0);

        // zero strobe still responds but changes nothing
        do_write(6'h08, 32'h55555555, 4'h0, 1, 0, 0);
        check("zero_strobe_reg2", 256'(regs_o[95:64]), 256'(32'hDEAD5678));

        // read of reg2 handshaken on the same edge as its write commit
        check("pre_race_awready", 256'(awready), 256'(1'b1));
        check("pre_race_arready", 256'(arready), 256'(1'b1));
        old = model[2];
        awaddr = 6'h08; wdata = 32'hA5A50F0F; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 6'h08;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b1;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        model_write(6'h08, 32'hA5A50F0F, 4'hF);
        check("race_bvalid", 256'(bvalid), 256'(1'b1));
        check("race_rvalid", 256'(rvalid), 256'(1'b1));
        check("race_rdata_old", 256'(rdata), 256'(old));
        check("race_regs", 256'(regs_o), model_flat());
        repeat (4) begin
            @(posedge aclk); #1;
            check("race_rdata_hold", 256'(rdata), 256'(old));
            check("race_arready_low", 256'(arready), 256'(1'b0));
            check("race_bvalid_hold", 256'(bvalid), 256'(1'b1));
        end

        // one-cycle reset while both responses are pending
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        model_clear();
        check_all_zero("midreset");
        do_write(6'h1C, 32'h0BADC0DE, 4'hF, 0, 0, 1);
        do_read(6'h1C, 0);
        do_read(6'h08, 0);

        // randomized traffic against the model
        repeat (40) begin
            ra = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1)
                do_write(ra, $urandom, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 2)));
            else
                do_read(ra, int'($urandom_range(0, 2)));
        end
        check("final_regs", 256'(regs_o), model_flat());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
